// File: rtl/pss_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pss_pkg
//  Description : Shared constants and types for the NR PSS sequence blocks.
//                Holds the sequence length, the three LFSR seeds (one per
//                N_id_2), the LFSR feedback taps and the generator state type.
//  Revision    : 1.0  initial release
// ============================================================================
package pss_pkg;

  localparam int PSS_LEN    = 127;
  localparam int LFSR_W     = 7;
  localparam int N_ID_2_MAX = 2;

  // Seeds hold x(43k .. 43k+6) with x(43k) in bit 0, so bit 0 of the LFSR
  // state is always the current sequence bit.
  localparam logic [LFSR_W-1:0] SEED_0 = 7'b1110110;  // x(0..6)   = 0,1,1,0,1,1,1
  localparam logic [LFSR_W-1:0] SEED_1 = 7'b0011000;  // x(43..49) = 0,0,0,1,1,0,0
  localparam logic [LFSR_W-1:0] SEED_2 = 7'b0111111;  // x(86..92) = 1,1,1,1,1,1,0

  // x(i+7) = x(i+4) ^ x(i): feedback taps relative to the current bit.
  localparam int LFSR_TAP_A = 4;
  localparam int LFSR_TAP_B = 0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LEAD  = 2'd1,
    ST_SEQ   = 2'd2,
    ST_TRAIL = 2'd3
  } pss_state_e;

  // Selector 3 is rejected before it gets here; it maps to SEED_0 only so
  // the function is total.
  function automatic logic [LFSR_W-1:0] pss_seed(input logic [1:0] n_id_2);
    logic [LFSR_W-1:0] seed;
    case (n_id_2)
      2'd1:    seed = SEED_1;
      2'd2:    seed = SEED_2;
      default: seed = SEED_0;
    endcase
    return seed;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pss_lfsr.sv
`default_nettype none
// ============================================================================
//  Module      : pss_lfsr
//  Description : Loadable 7-bit Fibonacci LFSR producing the PSS m-sequence.
//                State bit j holds x(i+j); bit 0 is the current output bit.
//  Ports       : clk      - clock, rising edge
//                rst      - synchronous active-high reset (state = SEED_0)
//                i_load   - load i_seed (has priority over i_adv)
//                i_seed   - seed value
//                i_adv    - advance one step
//                o_x      - current sequence bit x(i)
//                o_x_next - following sequence bit x(i+1)
//  Revision    : 1.0  initial release
// ============================================================================
module pss_lfsr
  import pss_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              i_load,
  input  logic [LFSR_W-1:0] i_seed,
  input  logic              i_adv,
  output logic              o_x,
  output logic              o_x_next
);

  logic [LFSR_W-1:0] r_state;
  logic              w_feedback;

  assign w_feedback = r_state[LFSR_TAP_A] ^ r_state[LFSR_TAP_B];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= SEED_0;
    end else if (i_load) begin
      r_state <= i_seed;
    end else if (i_adv) begin
      r_state <= {w_feedback, r_state[LFSR_W-1:1]};
    end
  end

  assign o_x      = r_state[0];
  // Exposed so a caller can register the post-advance bit in the same cycle.
  assign o_x_next = r_state[1];

endmodule
`default_nettype wire

// File: rtl/pss_generator.sv
`default_nettype none
// ============================================================================
//  Module      : pss_generator
//  Description : Generates one NR PSS symbol per start as a frequency-domain
//                AXI-Stream of BPSK samples: LEAD_ZEROS zero samples, the
//                127-sample m-sequence for the selected N_id_2, then
//                TRAIL_ZEROS zero samples. tlast marks the final sample.
//  Ports       : clk_i, reset_i       - clock / synchronous active-high reset
//                start_i, N_id_2_i    - symbol request and sequence selector
//                busy_o               - symbol in progress
//                error_o              - one-cycle pulse on rejected start
//                m_axis_out_*         - AXI-Stream master, tdata = {Q, I}
//  Revision    : 1.0  initial release
// ============================================================================
module pss_generator
  import pss_pkg::*;
#(
  parameter int SAMPLE_DW   = 16,
  parameter int AMPLITUDE   = 2**(SAMPLE_DW-2),
  parameter int LEAD_ZEROS  = 56,
  parameter int TRAIL_ZEROS = 57
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   start_i,
  input  logic [1:0]             N_id_2_i,
  output logic                   busy_o,
  output logic                   error_o,
  output logic [2*SAMPLE_DW-1:0] m_axis_out_tdata,
  output logic                   m_axis_out_tvalid,
  input  logic                   m_axis_out_tready,
  output logic                   m_axis_out_tlast
);

  localparam logic [7:0] c_LEAD_LAST  = 8'((LEAD_ZEROS  > 0) ? LEAD_ZEROS  - 1 : 0);
  localparam logic [7:0] c_TRAIL_LAST = 8'((TRAIL_ZEROS > 0) ? TRAIL_ZEROS - 1 : 0);
  localparam logic [7:0] c_SEQ_LAST   = 8'(PSS_LEN - 1);
  localparam logic [SAMPLE_DW-1:0]   c_POS  = SAMPLE_DW'(AMPLITUDE);
  localparam logic [SAMPLE_DW-1:0]   c_NEG  = -c_POS;
  localparam logic [2*SAMPLE_DW-1:0] c_ZERO = '0;

  // x = 0 maps to +A, x = 1 to -A; Q is always zero.
  function automatic logic [2*SAMPLE_DW-1:0] bpsk(input logic x);
    return {{SAMPLE_DW{1'b0}}, (x ? c_NEG : c_POS)};
  endfunction

  pss_state_e             r_state, w_state_nxt;
  logic [7:0]             r_cnt, w_cnt_nxt;
  logic [2*SAMPLE_DW-1:0] r_tdata, w_tdata_nxt;
  logic                   r_tvalid, w_tvalid_nxt;
  logic                   r_tlast, w_tlast_nxt;
  logic                   r_error, w_error_nxt;
  logic                   w_load, w_adv;
  logic                   w_xfer;
  logic                   w_x, w_x_next;
  logic [LFSR_W-1:0]      w_seed;

  assign w_xfer = r_tvalid & m_axis_out_tready;
  assign w_seed = pss_seed(N_id_2_i);

  pss_lfsr u_lfsr (
    .clk      (clk_i),
    .rst      (reset_i),
    .i_load   (w_load),
    .i_seed   (w_seed),
    .i_adv    (w_adv),
    .o_x      (w_x),
    .o_x_next (w_x_next)
  );

  // The output register always holds the sample being offered. The LFSR is
  // kept aligned so that, in SEQ, its current bit is the sample on the bus;
  // on a SEQ transfer the next sample therefore comes from o_x_next.
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_tdata_nxt  = r_tdata;
    w_tvalid_nxt = r_tvalid;
    w_tlast_nxt  = r_tlast;
    w_error_nxt  = 1'b0;
    w_load       = 1'b0;
    w_adv        = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (start_i) begin
          if (N_id_2_i <= 2'(N_ID_2_MAX)) begin
            w_load       = 1'b1;
            w_cnt_nxt    = 8'd0;
            w_tvalid_nxt = 1'b1;
            w_tlast_nxt  = 1'b0;
            if (LEAD_ZEROS > 0) begin
              w_state_nxt = ST_LEAD;
              w_tdata_nxt = c_ZERO;
            end else begin
              // LFSR is being loaded this cycle, so take the bit from the seed.
              w_state_nxt = ST_SEQ;
              w_tdata_nxt = bpsk(w_seed[0]);
            end
          end else begin
            w_error_nxt = 1'b1;
          end
        end
      end

      ST_LEAD: begin
        if (w_xfer) begin
          if (r_cnt == c_LEAD_LAST) begin
            w_state_nxt = ST_SEQ;
            w_cnt_nxt   = 8'd0;
            w_tdata_nxt = bpsk(w_x);
          end else begin
            w_cnt_nxt   = r_cnt + 8'd1;
            w_tdata_nxt = c_ZERO;
          end
        end
      end

      ST_SEQ: begin
        if (w_xfer) begin
          w_adv = 1'b1;
          if (r_cnt == c_SEQ_LAST) begin
            w_cnt_nxt = 8'd0;
            if (TRAIL_ZEROS > 0) begin
              w_state_nxt = ST_TRAIL;
              w_tdata_nxt = c_ZERO;
              w_tlast_nxt = (TRAIL_ZEROS == 1);
            end else begin
              w_state_nxt  = ST_IDLE;
              w_tdata_nxt  = c_ZERO;
              w_tvalid_nxt = 1'b0;
              w_tlast_nxt  = 1'b0;
            end
          end else begin
            w_cnt_nxt   = r_cnt + 8'd1;
            w_tdata_nxt = bpsk(w_x_next);
            // With no trailing pad the last sequence sample closes the frame.
            w_tlast_nxt = (TRAIL_ZEROS == 0) && (r_cnt == c_SEQ_LAST - 8'd1);
          end
        end
      end

      ST_TRAIL: begin
        if (w_xfer) begin
          if (r_cnt == c_TRAIL_LAST) begin
            w_state_nxt  = ST_IDLE;
            w_cnt_nxt    = 8'd0;
            w_tdata_nxt  = c_ZERO;
            w_tvalid_nxt = 1'b0;
            w_tlast_nxt  = 1'b0;
          end else begin
            w_cnt_nxt   = r_cnt + 8'd1;
            w_tdata_nxt = c_ZERO;
            w_tlast_nxt = ((r_cnt + 8'd1) == c_TRAIL_LAST);
          end
        end
      end

      default: begin
        w_state_nxt  = ST_IDLE;
        w_cnt_nxt    = 8'd0;
        w_tdata_nxt  = c_ZERO;
        w_tvalid_nxt = 1'b0;
        w_tlast_nxt  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state  <= ST_IDLE;
      r_cnt    <= 8'd0;
      r_tdata  <= '0;
      r_tvalid <= 1'b0;
      r_tlast  <= 1'b0;
      r_error  <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_tdata  <= w_tdata_nxt;
      r_tvalid <= w_tvalid_nxt;
      r_tlast  <= w_tlast_nxt;
      r_error  <= w_error_nxt;
    end
  end

  assign busy_o            = (r_state != ST_IDLE);
  assign error_o           = r_error;
  assign m_axis_out_tdata  = r_tdata;
  assign m_axis_out_tvalid = r_tvalid;
  assign m_axis_out_tlast  = r_tlast;

endmodule
`default_nettype wire

// File: tb/tb_pss_generator.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pss_generator
//  Description : Directed self-checking bench for pss_generator. Frames are
//                captured sample by sample and compared against a golden
//                m-sequence built from the recurrence, plus hand-written
//                sample values and correlation peaks.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_pss_generator;

  localparam int          FRAME  = 240;
  localparam int          LEAD   = 56;
  localparam int          AMP    = 16384;
  localparam logic [31:0] W_POS  = 32'h0000_4000;
  localparam logic [31:0] W_NEG  = 32'h0000_C000;

  logic        clk = 1'b0;
  logic        reset, start, tready;
  logic [1:0]  nid;
  logic        busy, error, tvalid, tlast;
  logic [31:0] tdata;

  always #5 clk = ~clk;

  pss_generator dut (
    .clk_i             (clk),
    .reset_i           (reset),
    .start_i           (start),
    .N_id_2_i          (nid),
    .busy_o            (busy),
    .error_o           (error),
    .m_axis_out_tdata  (tdata),
    .m_axis_out_tvalid (tvalid),
    .m_axis_out_tready (tready),
    .m_axis_out_tlast  (tlast)
  );

  int          n_checks = 0;
  int          n_errors = 0;
  bit          xg [0:126];
  logic [31:0] cap_data [0:255];
  bit          cap_last [0:255];
  int          n_cap;
  bit          got_last;
  int          stall_viol;
  bit          err_seen;

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_word(input int k, input int n);
    if (n < LEAD || n >= LEAD + 127) return 32'h0;
    return xg[(n - LEAD + 43 * k) % 127] ? W_NEG : W_POS;
  endfunction

  function automatic longint corr(input int k);
    longint acc = 0;
    for (int n = 0; n < 127; n++) begin
      longint s = longint'($signed(cap_data[LEAD + n][15:0]));
      acc += xg[(n + 43 * k) % 127] ? -s : s;
    end
    return acc;
  endfunction

  // Issue a one-cycle start from a falling edge; returns on the next one.
  task automatic do_start(input logic [1:0] k);
    start = 1'b1;
    nid   = k;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Collects transferred samples until tlast (or stop_at samples). Returns on
  // the falling edge after the tlast transfer.
  task automatic capture(input bit rnd, input bit inject, input int stop_at);
    bit          prev_stall = 1'b0;
    logic [31:0] prev_data  = '0;
    logic        prev_last  = 1'b0;
    n_cap = 0; got_last = 1'b0; stall_viol = 0; err_seen = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (inject) begin
        if (cyc == 50) begin start = 1'b1; nid = 2'd1; end
        if (cyc == 51) start = 1'b0;
        if (cyc == 60) begin start = 1'b1; nid = 2'd3; end
        if (cyc == 61) start = 1'b0;
      end
      if (prev_stall && (tdata !== prev_data || tlast !== prev_last || tvalid !== 1'b1))
        stall_viol++;
      tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (tvalid && tready) begin
        if (n_cap < 256) begin
          cap_data[n_cap] = tdata;
          cap_last[n_cap] = tlast;
        end
        n_cap++;
        if (tlast) got_last = 1'b1;
      end
      prev_stall = tvalid && !tready;
      prev_data  = tdata;
      prev_last  = tlast;
      if (error) err_seen = 1'b1;
      if (stop_at > 0 && n_cap == stop_at) break;
      @(negedge clk);
      if (got_last) break;
    end
    start = 1'b0;
    if (stop_at == 0) check("frame_tlast_seen", longint'(got_last), 1);
  endtask

  task automatic verify(input int k, input string tag);
    int bad = 0;
    int nl  = 0;
    check({tag, "_len"}, n_cap, FRAME);
    for (int n = 0; n < n_cap && n < 256; n++) begin
      if (cap_data[n] !== exp_word(k, n)) bad++;
      if (cap_last[n]) nl++;
    end
    check({tag, "_data_mismatches"}, bad, 0);
    check({tag, "_tlast_count"}, nl, 1);
    check({tag, "_tlast_pos"}, longint'(cap_last[FRAME-1]), 1);
    for (int j = 0; j < 3; j++)
      check({tag, "_corr"}, corr(j), (j == k) ? 127 * AMP : -AMP);
  endtask

  logic [31:0] hand0 [0:6];
  logic [31:0] hand1 [0:6];

  initial begin
    hand0 = '{W_POS, W_NEG, W_NEG, W_POS, W_NEG, W_NEG, W_NEG};
    hand1 = '{W_POS, W_POS, W_POS, W_NEG, W_NEG, W_POS, W_POS};
    xg[0] = 0; xg[1] = 1; xg[2] = 1; xg[3] = 0; xg[4] = 1; xg[5] = 1; xg[6] = 1;
    for (int i = 7; i < 127; i++) xg[i] = xg[i-3] ^ xg[i-7];

    reset = 1'b1; start = 1'b0; nid = 2'd0; tready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_tvalid", tvalid, 0);
    check("rst_tlast",  tlast,  0);
    check("rst_busy",   busy,   0);
    check("rst_error",  error,  0);
    check("rst_tdata",  tdata,  0);
    reset = 1'b0;
    @(negedge clk);

    // N_id_2 = 0, full-rate
    do_start(2'd0);
    check("lat_tvalid", tvalid, 1);
    check("lat_busy",   busy,   1);
    capture(1'b0, 1'b0, 0);
    verify(0, "nid0");
    for (int i = 0; i < 7; i++) check("nid0_hand", cap_data[LEAD + i], hand0[i]);
    check("gap_busy",   busy,   0);
    check("gap_tvalid", tvalid, 0);

    // back-to-back: start in the cycle busy falls
    do_start(2'd1);
    check("b2b_tvalid", tvalid, 1);
    capture(1'b0, 1'b0, 0);
    verify(1, "nid1");
    for (int i = 0; i < 7; i++) check("nid1_hand", cap_data[LEAD + i], hand1[i]);

    // N_id_2 = 2 with ignored mid-frame starts
    @(negedge clk);
    do_start(2'd2);
    capture(1'b0, 1'b1, 0);
    verify(2, "nid2");
    check("midstart_no_error", longint'(err_seen), 0);

    // random backpressure
    @(negedge clk);
    do_start(2'd0);
    capture(1'b1, 1'b0, 0);
    verify(0, "rnd");
    check("rnd_stable", stall_viol, 0);

    // invalid selector
    @(negedge clk);
    do_start(2'd3);
    check("inv_error",  error,  1);
    check("inv_tvalid", tvalid, 0);
    check("inv_busy",   busy,   0);
    @(negedge clk);
    check("inv_error_pulse", error,  0);
    check("inv_tvalid2",     tvalid, 0);

    // reset at sample 100
    do_start(2'd1);
    capture(1'b0, 1'b0, 100);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("mrst_tvalid", tvalid, 0);
    check("mrst_busy",   busy,   0);
    check("mrst_tlast",  tlast,  0);
    check("mrst_tdata",  tdata,  0);
    @(negedge clk);
    do_start(2'd2);
    capture(1'b0, 1'b0, 0);
    verify(2, "post_rst");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
